// File: rtl/age_issue_select.sv
// Oldest-first issue selector for one execution unit: tree pick, registered issue stage, one-hot clear back to the queue.
// Latency: clear_entry in the pick cycle, issue_valid the next cycle; stalls on !exe_ready, waits for muti_finish when multi-cycle.
module age_issue_select #(
    parameter int ENTRIES      = 16,
    parameter int AGE_WIDTH    = 5,
    parameter int OPCODE_WIDTH = 7,
    parameter int MULTI_CYCLE  = 0,
    parameter int IDX_W        = $clog2(ENTRIES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OPCODE_WIDTH-1:0]         op_correct,
    input  logic [ENTRIES-1:0]              req_valid,
    input  logic [ENTRIES*OPCODE_WIDTH-1:0] req_op,
    input  logic [ENTRIES*AGE_WIDTH-1:0]    req_age,
    input  logic                            flush,
    input  logic                            exe_ready,
    input  logic                            muti_finish,
    output logic                            issue_valid,
    output logic [IDX_W-1:0]                issue_addr,
    output logic [AGE_WIDTH-1:0]            issue_age,
    output logic [ENTRIES-1:0]              clear_entry,
    output logic                            unit_busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]       issue_addr_q, issue_addr_d;
    logic [AGE_WIDTH-1:0]   issue_age_q, issue_age_d;

    logic [ENTRIES-1:0]     eligible;
    logic                   node_vld [1:2*ENTRIES-1];
    logic [IDX_W-1:0]       node_idx [1:2*ENTRIES-1];
    logic [AGE_WIDTH-1:0]   node_age [1:2*ENTRIES-1];
    logic                   accept, finish_ok, load_ok, capture;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            eligible[i] = req_valid[i] && (req_op[i*OPCODE_WIDTH +: OPCODE_WIDTH] == op_correct);
        end
    end

    // Heap-ordered tree: leaves at ENTRIES+i, left child always covers the lower indices,
    // so taking the right child only on strictly smaller age gives the lower-index tie-break.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            node_vld[ENTRIES+i] = eligible[i];
            node_idx[ENTRIES+i] = IDX_W'(i);
            node_age[ENTRIES+i] = req_age[i*AGE_WIDTH +: AGE_WIDTH];
        end
        for (int n = ENTRIES - 1; n >= 1; n--) begin
            if (node_vld[2*n+1] && (!node_vld[2*n] || (node_age[2*n+1] < node_age[2*n]))) begin
                node_vld[n] = 1'b1;
                node_idx[n] = node_idx[2*n+1];
                node_age[n] = node_age[2*n+1];
            end else begin
                node_vld[n] = node_vld[2*n];
                node_idx[n] = node_idx[2*n];
                node_age[n] = node_age[2*n];
            end
        end
    end

    always_comb begin
        accept    = issue_valid_q && exe_ready;
        finish_ok = (MULTI_CYCLE != 0) && muti_finish;
        load_ok   = (!issue_valid_q || exe_ready) && !flush && ((state_q == IDLE) || finish_ok);
        capture   = node_vld[1] && load_ok && !rst;

        clear_entry = '0;
        if (capture) begin
            clear_entry[node_idx[1]] = 1'b1;
        end

        issue_valid_d = issue_valid_q;
        issue_addr_d  = issue_addr_q;
        issue_age_d   = issue_age_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (capture) begin
            issue_valid_d = 1'b1;
            issue_addr_d  = node_idx[1];
            issue_age_d   = node_age[1];
        end else if (accept) begin
            issue_valid_d = 1'b0;
        end

        state_d = state_q;
        if (MULTI_CYCLE == 0 || flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = BUSY;
                BUSY:    if (muti_finish && !accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            issue_valid_q <= 1'b0;
            issue_addr_q  <= '0;
            issue_age_q   <= '0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_addr_q  <= issue_addr_d;
            issue_age_q   <= issue_age_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_addr  = issue_addr_q;
    assign issue_age   = issue_age_q;
    assign unit_busy   = (state_q == BUSY);

endmodule

// File: tb/tb_age_issue_select.sv
// Bench for age_issue_select: a single-cycle unit and a multi-cycle unit share one set of stimulus.
module tb_age_issue_select;

    localparam logic [6:0] OP_OK  = 7'h11;
    localparam logic [6:0] OP_BAD = 7'h22;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   op_correct;
    logic [15:0]  req_valid;
    logic [111:0] req_op;
    logic [79:0]  req_age;
    logic         flush, exe_ready, muti_finish;

    logic         iv0, iv1, ub0, ub1;
    logic [3:0]   ia0, ia1;
    logic [4:0]   ig0, ig1;
    logic [15:0]  ce0, ce1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    age_issue_select #(.ENTRIES(16), .AGE_WIDTH(5), .OPCODE_WIDTH(7), .MULTI_CYCLE(0)) dut0 (
        .clk(clk), .rst(rst), .op_correct(op_correct), .req_valid(req_valid), .req_op(req_op),
        .req_age(req_age), .flush(flush), .exe_ready(exe_ready), .muti_finish(muti_finish),
        .issue_valid(iv0), .issue_addr(ia0), .issue_age(ig0), .clear_entry(ce0), .unit_busy(ub0));

    age_issue_select #(.ENTRIES(16), .AGE_WIDTH(5), .OPCODE_WIDTH(7), .MULTI_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .op_correct(op_correct), .req_valid(req_valid), .req_op(req_op),
        .req_age(req_age), .flush(flush), .exe_ready(exe_ready), .muti_finish(muti_finish),
        .issue_valid(iv1), .issue_addr(ia1), .issue_age(ig1), .clear_entry(ce1), .unit_busy(ub1));

    typedef struct packed {
        logic [15:0] vld;
        logic [15:0] opm;
        logic [79:0] age;
        logic [15:0] exp_clr;
        logic        exp_cap;
        logic [3:0]  exp_addr;
        logic [4:0]  exp_age;
    } vec_t;

    typedef struct packed {
        logic       cap;
        logic [3:0] addr;
        logic [4:0] age;
    } exp_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    exp_t sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_op    = '0;
        req_age   = '0;
    endtask

    task automatic add_req(input int e, input logic [4:0] a);
        req_valid[e]      = 1'b1;
        req_op[e*7 +: 7]  = OP_OK;
        req_age[e*5 +: 5] = a;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] ages_all(input logic [4:0] a);
        logic [79:0] r;
        for (int e = 0; e < 16; e++) r[e*5 +: 5] = a;
        return r;
    endfunction

    task automatic set_vec(input int k, input logic [15:0] vld, input logic [15:0] opm,
                           input logic [4:0] fill, input logic [15:0] clr, input logic cap,
                           input logic [3:0] addr, input logic [4:0] age);
        vecs[k].vld      = vld;
        vecs[k].opm      = opm;
        vecs[k].age      = ages_all(fill);
        vecs[k].exp_clr  = clr;
        vecs[k].exp_cap  = cap;
        vecs[k].exp_addr = addr;
        vecs[k].exp_age  = age;
    endtask

    // Output stage of the single-cycle unit against what was captured one cycle earlier.
    task automatic sb_check(input int k);
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("sb%0d issue_valid", k), 32'(iv0), 32'(x.cap));
            if (x.cap) begin
                chk($sformatf("sb%0d issue_addr", k), 32'(ia0), 32'(x.addr));
                chk($sformatf("sb%0d issue_age", k), 32'(ig0), 32'(x.age));
            end
        end
    endtask

    initial begin
        set_vec(0, 16'h1208, 16'hFFFF, 5'd31, 16'h0200, 1'b1, 4'd9, 5'd2);
        vecs[0].age[3*5 +: 5] = 5'd7;
        vecs[0].age[9*5 +: 5] = 5'd2;
        vecs[0].age[12*5 +: 5] = 5'd5;
        set_vec(1, 16'h0811, 16'hFFFE, 5'd3, 16'h0010, 1'b1, 4'd4, 5'd3);
        vecs[1].age[0 +: 5] = 5'd0;
        set_vec(2, 16'h0000, 16'hFFFF, 5'd4, 16'h0000, 1'b0, 4'd0, 5'd0);
        set_vec(3, 16'hFFFF, 16'hFFFF, 5'd20, 16'h8000, 1'b1, 4'd15, 5'd1);
        vecs[3].age[15*5 +: 5] = 5'd1;
        set_vec(4, 16'hFFFF, 16'hFFFF, 5'd9, 16'h0001, 1'b1, 4'd0, 5'd9);
        set_vec(5, 16'hFFFF, 16'h0000, 5'd1, 16'h0000, 1'b0, 4'd0, 5'd0);
        set_vec(6, 16'h8001, 16'hFFFF, 5'd31, 16'h8000, 1'b1, 4'd15, 5'd30);
        vecs[6].age[15*5 +: 5] = 5'd30;
        set_vec(7, 16'h0400, 16'hFFFF, 5'd12, 16'h0400, 1'b1, 4'd10, 5'd12);
        vecs[7].age[2*5 +: 5] = 5'd0;

        op_correct  = OP_OK;
        flush       = 1'b0;
        exe_ready   = 1'b1;
        muti_finish = 1'b0;
        rst         = 1'b1;
        clr_req();
        add_req(1, 5'd0);

        // Reset: no clear while rst is high, all outputs zero after the edge.
        @(negedge clk);
        chk("rst clear0", 32'(ce0), 32'h0);
        chk("rst clear1", 32'(ce1), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rst valid0", 32'(iv0), 32'h0);
        chk("rst addr0", 32'(ia0), 32'h0);
        chk("rst age0", 32'(ig0), 32'h0);
        chk("rst busy0", 32'(ub0), 32'h0);
        chk("rst valid1", 32'(iv1), 32'h0);
        chk("rst busy1", 32'(ub1), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Table vectors, one per cycle with exe_ready high: full-throughput capture and drain.
        for (int k = 0; k < NV; k++) begin
            req_valid = vecs[k].vld;
            for (int e = 0; e < 16; e++) req_op[e*7 +: 7] = vecs[k].opm[e] ? OP_OK : OP_BAD;
            req_age   = vecs[k].age;
            @(negedge clk);
            sb_check(k);
            chk($sformatf("v%0d clear_entry", k), 32'(ce0), 32'(vecs[k].exp_clr));
            sb.push_back('{vecs[k].exp_cap, vecs[k].exp_addr, vecs[k].exp_age});
            next_cycle();
        end
        clr_req();
        @(negedge clk);
        sb_check(NV);
        next_cycle();

        // Stall on the single-cycle unit: two cycles of !exe_ready, then capture on the ready cycle.
        add_req(2, 5'd4);
        @(negedge clk);
        chk("stall cap clear", 32'(ce0), 32'h0004);
        next_cycle();
        clr_req();
        add_req(5, 5'd1);
        exe_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d clear", s), 32'(ce0), 32'h0);
            chk($sformatf("stall%0d valid", s), 32'(iv0), 32'h1);
            chk($sformatf("stall%0d addr", s), 32'(ia0), 32'h2);
            next_cycle();
        end
        exe_ready = 1'b1;
        @(negedge clk);
        chk("ready clear", 32'(ce0), 32'h0020);
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("ready valid", 32'(iv0), 32'h1);
        chk("ready addr", 32'(ia0), 32'h5);
        chk("ready age", 32'(ig0), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("drain valid", 32'(iv0), 32'h0);
        next_cycle();

        // Multi-cycle unit: fresh reset, then accept at t and finish at t+4.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        add_req(6, 5'd3);
        @(negedge clk);
        chk("mc cap clear", 32'(ce1), 32'h0040);
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("mc t valid", 32'(iv1), 32'h1);
        chk("mc t addr", 32'(ia1), 32'h6);
        chk("mc t busy", 32'(ub1), 32'h0);
        next_cycle();
        add_req(7, 5'd2);
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            chk($sformatf("mc t+%0d busy", s), 32'(ub1), 32'h1);
            chk($sformatf("mc t+%0d clear", s), 32'(ce1), 32'h0);
            chk($sformatf("mc t+%0d valid", s), 32'(iv1), 32'h0);
            next_cycle();
        end
        muti_finish = 1'b1;
        @(negedge clk);
        chk("mc t+4 busy", 32'(ub1), 32'h1);
        chk("mc t+4 clear", 32'(ce1), 32'h0080);
        next_cycle();
        muti_finish = 1'b0;
        clr_req();
        add_req(8, 5'd1);
        @(negedge clk);
        chk("mc t+5 valid", 32'(iv1), 32'h1);
        chk("mc t+5 addr", 32'(ia1), 32'h7);
        chk("mc t+5 busy", 32'(ub1), 32'h0);
        chk("mc accept+cap clear", 32'(ce1), 32'h0100);
        next_cycle();

        // Flush while busy with a held issue and an eligible request.
        clr_req();
        add_req(9, 5'd0);
        flush     = 1'b1;
        exe_ready = 1'b0;
        @(negedge clk);
        chk("pre-flush busy", 32'(ub1), 32'h1);
        chk("pre-flush valid", 32'(iv1), 32'h1);
        chk("pre-flush addr", 32'(ia1), 32'h8);
        chk("flush clear", 32'(ce1), 32'h0);
        next_cycle();
        flush = 1'b0;
        clr_req();
        @(negedge clk);
        chk("post-flush valid", 32'(iv1), 32'h0);
        chk("post-flush busy", 32'(ub1), 32'h0);
        next_cycle();

        // Reset in the middle of BUSY with a held issue.
        exe_ready = 1'b1;
        add_req(3, 5'd2);
        @(negedge clk);
        chk("rb cap clear", 32'(ce1), 32'h0008);
        next_cycle();
        clr_req();
        add_req(4, 5'd6);
        @(negedge clk);
        chk("rb accept+cap clear", 32'(ce1), 32'h0010);
        next_cycle();
        clr_req();
        add_req(5, 5'd1);
        exe_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("rb pre busy", 32'(ub1), 32'h1);
        chk("rb pre valid", 32'(iv1), 32'h1);
        chk("rb pre addr", 32'(ia1), 32'h4);
        chk("rb clear in rst", 32'(ce1), 32'h0);
        next_cycle();
        rst = 1'b0;
        clr_req();
        muti_finish = 1'b1;
        @(negedge clk);
        chk("rb valid", 32'(iv1), 32'h0);
        chk("rb addr", 32'(ia1), 32'h0);
        chk("rb age", 32'(ig1), 32'h0);
        chk("rb busy", 32'(ub1), 32'h0);
        next_cycle();
        muti_finish = 1'b0;
        @(negedge clk);
        chk("rb finish ignored busy", 32'(ub1), 32'h0);
        chk("rb finish ignored valid", 32'(iv1), 32'h0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
